// File: rtl/lcg_stim_pkg.sv
// Shared constants, FSM state type and chunk-count helper for the LCG stimulus generator.
package lcg_stim_pkg;

    localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC = 32'h0000_3039;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of 32-bit LCG steps needed to fill a vector of width w.
    function automatic int nch(input int w);
        return (w + 31) / 32;
    endfunction

endpackage

// File: rtl/lcg_stim_gen_step.sv
// One combinational LCG step: s' = s * LCG_MUL + LCG_INC, truncated to 32 bits.
module lcg_step
    import lcg_stim_pkg::*;
(
    input  logic [31:0] s_in,
    output logic [31:0] s_out
);

    assign s_out = s_in * LCG_MUL + LCG_INC;

endmodule

// File: rtl/lcg_stim_gen.sv
// Wide-vector LCG stimulus generator with valid/ready output and IDLE/RUN/DONE control.
// Optional signature output is enabled by defining LCG_STIM_SIGNATURE_EN.
module lcg_stim_gen
    import lcg_stim_pkg::*;
#(
    parameter int OUT_W = 263,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] cycles,
    output logic             stim_valid,
    input  logic             stim_ready,
    output logic [OUT_W-1:0] stim_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] xfer_count
`ifdef LCG_STIM_SIGNATURE_EN
    ,
    output logic [31:0]      signature
`endif
);

    localparam int NCH    = nch(OUT_W);
    localparam int LAST_W = OUT_W - 32 * (NCH - 1);

    state_t           state;
    logic [31:0]      lcg_state;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] xfer_next;
    logic [CNT_W-1:0] xfer_last;
    logic [31:0]      chain_base;
    logic [31:0]      chain_end;
    logic [OUT_W-1:0] stim_next;
    logic             xfer;

    // Outside RUN the chain is seeded from the input so an accepted start loads vector 0 directly.
    assign chain_base = (state == RUN) ? lcg_state : seed;

    for (genvar k = 0; k < NCH; k++) begin : g_step
        logic [31:0] s_in;
        logic [31:0] s_out;

        if (k == 0) begin : g_first
            assign s_in = chain_base;
        end else begin : g_next
            assign s_in = g_step[k-1].s_out;
        end

        lcg_step u_step (
            .s_in  (s_in),
            .s_out (s_out)
        );

        if (k < NCH - 1) begin : g_full
            assign stim_next[32*k +: 32] = s_out;
        end else begin : g_last
            assign stim_next[OUT_W-1 -: LAST_W] = s_out[LAST_W-1:0];
        end
    end

    assign chain_end = g_step[NCH-1].s_out;
    assign xfer      = stim_valid && stim_ready;
    assign xfer_next = xfer_count + CNT_W'(1);
    assign xfer_last = cycles_q + CNT_W'(1);

`ifdef LCG_STIM_SIGNATURE_EN
    localparam int PAD_W = NCH * 32;
    logic [PAD_W-1:0] padded;
    logic [31:0]      fold;

    assign padded = PAD_W'(stim_data);

    always_comb begin
        fold = '0;
        for (int k = 0; k < NCH; k++) begin
            fold = fold ^ padded[32*k +: 32];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            stim_valid <= 1'b0;
            stim_data  <= '0;
            xfer_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lcg_state  <= '0;
            cycles_q   <= '0;
`ifdef LCG_STIM_SIGNATURE_EN
            signature  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        stim_data  <= stim_next;
                        lcg_state  <= chain_end;
                        cycles_q   <= cycles;
                        xfer_count <= '0;
                        stim_valid <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
`ifdef LCG_STIM_SIGNATURE_EN
                        signature  <= '0;
`endif
                    end
                end
                RUN: begin
                    // Comparison is done modulo 2^CNT_W so all-ones cycles gives a full wrap.
                    if (xfer) begin
                        xfer_count <= xfer_next;
`ifdef LCG_STIM_SIGNATURE_EN
                        signature  <= {signature[30:0], signature[31]} ^ fold;
`endif
                        if (xfer_next == xfer_last) begin
                            state      <= DONE;
                            stim_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            stim_data  <= stim_next;
                            lcg_state  <= chain_end;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    stim_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
